// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Pure combinational BCD nibble to 7-segment pattern, with a blank override.
// Non-BCD nibbles (A..F) show a dash as an error indication.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      unique case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Latches four BCD digits and scans them one slot every DIV enabled cycles,
// driving decoder select lines (b,a) and the segment pattern of the selected digit.
module digit_scan_controller
  import display_pkg::*;
#(
  parameter int DIV      = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic        a,
  output logic        b,
  output logic [6:0]  seg,
  output logic        tick
);

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_idx;
  logic [15:0]           r_data;
  logic                  w_tick;
  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]            w_digit;
  logic                  w_blank;

  assign w_tick = en & (r_cnt == CNT_MAX);

  // load is a single-cycle strobe with no back-pressure; it never disturbs the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_data <= 16'h0000;
    end else begin
      if (en) begin
        if (w_tick) begin
          r_cnt <= '0;
          r_idx <= r_idx + 2'd1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (load) begin
        r_data <= bcd_in;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  // Invalid nibbles are nonzero and therefore stop the blanking chain.
  always_comb begin
    w_lz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_zero[k] = (r_data[4*k +: 4] == 4'd0);
    end
    w_lz[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
    for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
      w_lz[k] = w_zero[k] & w_lz[k+1];
    end
  end

  assign w_digit = r_data[{r_idx, 2'b00} +: 4];
  assign w_blank = BLANK_LZ & w_lz[r_idx];

  bcd_to_seg u_bcd_to_seg (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (seg)
  );

  assign a    = r_idx[0];
  assign b    = r_idx[1];
  assign tick = w_tick;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Self-checking bench for digit_scan_controller: directed scenarios plus random
// traffic, compared each cycle against a behavioural model of the display scan.
module tb_digit_scan_controller;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] bcd_in;
  logic        a, b, tick;
  logic [6:0]  seg;
  logic        a_nb, b_nb, tick_nb;
  logic [6:0]  seg_nb;

  int          errors = 0;
  int          checks = 0;

  // behavioural model state
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_data;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  digit_scan_controller #(.DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
    .a(a), .b(b), .seg(seg), .tick(tick)
  );

  digit_scan_controller #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
    .a(a_nb), .b(b_nb), .seg(seg_nb), .tick(tick_nb)
  );

  // ---------------- model ----------------
  function automatic logic [6:0] exp_seg(logic [15:0] data, int idx, bit blz);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = data >> (4 * idx);
    nib   = upper[3:0];
    // the number formed by this digit and all higher ones is zero -> leading zero
    if (blz && idx > 0 && upper == 16'h0) return 7'h00;
    if (nib > 4'd9) return 7'h40;
    return seg_tab[nib];
  endfunction

  task automatic model_step();
    if (rst) begin
      m_cnt  = 0;
      m_idx  = 0;
      m_data = 16'h0;
    end else begin
      if (en) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (load) m_data = bcd_in;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_tick;
    exp_tick = en && (m_cnt == DIV - 1);
    check({tag, ".a"},       16'(a),       16'(m_idx % 2));
    check({tag, ".b"},       16'(b),       16'(m_idx / 2));
    check({tag, ".tick"},    16'(tick),    16'(exp_tick));
    check({tag, ".seg"},     16'(seg),     16'(exp_seg(m_data, m_idx, 1'b1)));
    check({tag, ".a_nb"},    16'(a_nb),    16'(m_idx % 2));
    check({tag, ".b_nb"},    16'(b_nb),    16'(m_idx / 2));
    check({tag, ".tick_nb"}, 16'(tick_nb), 16'(exp_tick));
    check({tag, ".seg_nb"},  16'(seg_nb),  16'(exp_seg(m_data, m_idx, 1'b0)));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string tag, input logic r, input logic e,
                       input logic l, input logic [15:0] d);
    rst = r; en = e; load = l; bcd_in = d;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0;
    m_cnt = 0; m_idx = 0; m_data = 16'h0;

    // 1. reset release, then hold with en=0
    repeat (2) cycle("reset", 1'b1, 1'b0, 1'b0, 16'h0);
    check("reset.seg_const", 16'(seg), 16'h3F);
    repeat (10) cycle("idle", 1'b0, 1'b0, 1'b0, 16'h0);

    // 2. scan order with 1234
    cycle("load1234", 1'b0, 1'b1, 1'b1, 16'h1234);
    repeat (20) cycle("scan1234", 1'b0, 1'b1, 1'b0, 16'h0);

    // 3. leading-zero blanking
    cycle("load0050", 1'b0, 1'b1, 1'b1, 16'h0050);
    repeat (16) cycle("scan0050", 1'b0, 1'b1, 1'b0, 16'h0);

    // 4. invalid digit stops blanking
    cycle("load0A00", 1'b0, 1'b1, 1'b1, 16'h0A00);
    repeat (16) cycle("scan0A00", 1'b0, 1'b1, 1'b0, 16'h0);

    // 5. freeze at idx=2, then load on a tick cycle
    for (int i = 0; i < 20 && m_idx != 2; i++) cycle("to_idx2", 1'b0, 1'b1, 1'b0, 16'h0);
    check("reach_idx2", 16'({b, a}), 16'd2);
    repeat (7) cycle("freeze", 1'b0, 1'b0, 1'b0, 16'h0);
    check("freeze_idx", 16'({b, a}), 16'd2);
    for (int i = 0; i < 10 && m_cnt != DIV - 1; i++) cycle("to_tick", 1'b0, 1'b1, 1'b0, 16'h0);
    check("on_tick", 16'(tick), 16'd1);
    cycle("load_on_tick", 1'b0, 1'b1, 1'b1, 16'h7000);
    check("collide_idx", 16'({b, a}), 16'd3);
    check("collide_seg", 16'(seg), 16'h07);
    repeat (6) cycle("after_collide", 1'b0, 1'b1, 1'b0, 16'h0);

    // 6. mid-scan reset at idx=3, cnt=2
    cycle("load5678", 1'b0, 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 40 && !(m_idx == 3 && m_cnt == 2); i++)
      cycle("to_idx3", 1'b0, 1'b1, 1'b0, 16'h0);
    check("reach_idx3", 16'({b, a}), 16'd3);
    cycle("midreset", 1'b1, 1'b1, 1'b0, 16'h0);
    check("midreset.seg_const", 16'(seg), 16'h3F);
    repeat (DIV + 2) cycle("post_reset", 1'b0, 1'b1, 1'b0, 16'h0);

    // 7. random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 7) == 0),
            16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
